// File: rtl/evrisim_denetleyici.sv
// evrisim_denetleyici: frame sequencer in front of the 3x3 convolution unit.
// Holds host-written filter presets, loads one per frame, streams the frame's
// pixels into the convolution unit and collects its results with a timeout.
//
// Ports:
//   clk_i, rstn_i            clock, synchronous active-low reset
//   ayar_*_i                 preset bank write (slot, 72-bit coeffs, gaussian flag)
//   baslat_i, filtre_sec_i   frame start pulse and preset slot for the frame
//   pik_gecerli_i/pik_i/pik_hazir_o       pixel source valid/ready stream
//   evr_filtre_etkin_o/evr_filtre_o/evr_gaus_o  filter load to conv unit
//   evr_veri_etkin_o/evr_veri_o           pixels to conv unit
//   evr_veri_etkin_i/evr_veri_i           results from conv unit
//   cikis_gecerli_o/cikis_o               results to sink
//   mesgul_o, bitti_o, hata_o             status to control plane
//
// Optional: define EVRISIM_PERF_SAYAC_EN to add perf_dongu_o / perf_durak_o.
module evrisim_denetleyici #(
    parameter int GENISLIK    = 320,
    parameter int YUKSEKLIK   = 240,
    parameter int NUM_FILTRE  = 4,
    parameter int ZAMAN_ASIMI = 4096,
    localparam int AW         = $clog2(NUM_FILTRE)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          ayar_yaz_i,
    input  logic [AW-1:0] ayar_adres_i,
    input  logic [71:0]   ayar_filtre_i,
    input  logic          ayar_gaus_i,
    input  logic          baslat_i,
    input  logic [AW-1:0] filtre_sec_i,
    input  logic          pik_gecerli_i,
    input  logic [7:0]    pik_i,
    output logic          pik_hazir_o,
    output logic          evr_filtre_etkin_o,
    output logic [71:0]   evr_filtre_o,
    output logic          evr_gaus_o,
    output logic          evr_veri_etkin_o,
    output logic [7:0]    evr_veri_o,
    input  logic          evr_veri_etkin_i,
    input  logic [7:0]    evr_veri_i,
    output logic          cikis_gecerli_o,
    output logic [7:0]    cikis_o,
    output logic          mesgul_o,
    output logic          bitti_o,
    output logic          hata_o
`ifdef EVRISIM_PERF_SAYAC_EN
    ,
    output logic [31:0]   perf_dongu_o,
    output logic [31:0]   perf_durak_o
`endif
);

    typedef enum logic [2:0] {
        BOSTA,
        YUKLE,
        AKIS,
        BOSALT,
        BITTI
    } durum_t;

    localparam logic [16:0] TOPLAM = 17'(GENISLIK * YUKSEKLIK);
    localparam int          IW     = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [IW-1:0] SINIR = IW'(ZAMAN_ASIMI);

    durum_t        durum_q, durum_d;
    logic [16:0]   giris_q, giris_d;
    logic [16:0]   cikis_sayac_q, cikis_sayac_d;
    logic [IW-1:0] bos_q, bos_d;
    logic          hata_q, hata_d;

    logic [71:0]   filtre_q;
    logic          gaus_q;
    logic          veri_etkin_q;
    logic [7:0]    veri_q;
    logic          cgec_q;
    logic [7:0]    cik_q;

    logic [71:0]   bank_filtre_q [NUM_FILTRE];
    logic          bank_gaus_q   [NUM_FILTRE];

    logic          hazir;
    logic          el_sik;
    logic          kabul;

    assign hazir  = (durum_q == AKIS) && (giris_q < TOPLAM);
    assign el_sik = pik_gecerli_i & hazir;
    assign kabul  = (durum_q == BOSTA) & baslat_i;

    always_comb begin
        durum_d            = durum_q;
        giris_d            = giris_q;
        cikis_sayac_d      = cikis_sayac_q;
        bos_d              = bos_q;
        hata_d             = hata_q;
        pik_hazir_o        = hazir;
        evr_filtre_etkin_o = 1'b0;
        mesgul_o           = (durum_q != BOSTA);
        bitti_o            = 1'b0;

        // Results past the frame size are forwarded but never counted.
        if ((durum_q == AKIS || durum_q == BOSALT) &&
            evr_veri_etkin_i && (cikis_sayac_q < TOPLAM)) begin
            cikis_sayac_d = cikis_sayac_q + 17'd1;
        end

        unique case (durum_q)
            BOSTA: begin
                if (baslat_i) begin
                    durum_d = YUKLE;
                    hata_d  = 1'b0;
                end
            end
            YUKLE: begin
                evr_filtre_etkin_o = 1'b1;
                giris_d            = '0;
                cikis_sayac_d      = '0;
                bos_d              = '0;
                durum_d            = AKIS;
            end
            AKIS: begin
                if (el_sik) begin
                    giris_d = giris_q + 17'd1;
                    if (giris_d == TOPLAM) begin
                        durum_d = BOSALT;
                    end
                end
            end
            BOSALT: begin
                bos_d = evr_veri_etkin_i ? '0 : bos_q + 1'b1;
                // Completion takes priority over a coincident timeout.
                if (cikis_sayac_d == TOPLAM) begin
                    durum_d = BITTI;
                end else if (bos_d == SINIR) begin
                    hata_d  = 1'b1;
                    durum_d = BOSTA;
                end
            end
            BITTI: begin
                bitti_o = 1'b1;
                durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum_q       <= BOSTA;
            giris_q       <= '0;
            cikis_sayac_q <= '0;
            bos_q         <= '0;
            hata_q        <= 1'b0;
        end else begin
            durum_q       <= durum_d;
            giris_q       <= giris_d;
            cikis_sayac_q <= cikis_sayac_d;
            bos_q         <= bos_d;
            hata_q        <= hata_d;
        end
    end

    // Filter is captured when the start is accepted, so later writes to the
    // same slot cannot disturb the running frame.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_FILTRE; i++) begin
                bank_filtre_q[i] <= '0;
                bank_gaus_q[i]   <= 1'b0;
            end
            filtre_q     <= '0;
            gaus_q       <= 1'b0;
            veri_etkin_q <= 1'b0;
            veri_q       <= '0;
            cgec_q       <= 1'b0;
            cik_q        <= '0;
        end else begin
            if (ayar_yaz_i) begin
                bank_filtre_q[ayar_adres_i] <= ayar_filtre_i;
                bank_gaus_q[ayar_adres_i]   <= ayar_gaus_i;
            end
            if (kabul) begin
                filtre_q <= bank_filtre_q[filtre_sec_i];
                gaus_q   <= bank_gaus_q[filtre_sec_i];
            end
            veri_etkin_q <= el_sik;
            if (el_sik) begin
                veri_q <= pik_i;
            end
            cgec_q <= evr_veri_etkin_i;
            cik_q  <= evr_veri_i;
        end
    end

    assign evr_filtre_o     = filtre_q;
    assign evr_gaus_o       = gaus_q;
    assign evr_veri_etkin_o = veri_etkin_q;
    assign evr_veri_o       = veri_q;
    assign cikis_gecerli_o  = cgec_q;
    assign cikis_o          = cik_q;
    assign hata_o           = hata_q;

`ifdef EVRISIM_PERF_SAYAC_EN
    logic [31:0] dongu_q;
    logic [31:0] durak_q;

    // Counters freeze outside AKIS/BOSALT, holding the last frame's figures.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dongu_q <= '0;
            durak_q <= '0;
        end else if (durum_q == YUKLE) begin
            dongu_q <= '0;
            durak_q <= '0;
        end else begin
            if ((durum_q == AKIS || durum_q == BOSALT) && (dongu_q != '1)) begin
                dongu_q <= dongu_q + 32'd1;
            end
            if (hazir && !pik_gecerli_i && (durak_q != '1)) begin
                durak_q <= durak_q + 32'd1;
            end
        end
    end

    assign perf_dongu_o = dongu_q;
    assign perf_durak_o = durak_q;
`endif

endmodule

// File: tb/tb_evrisim_denetleyici.sv
// Testbench for evrisim_denetleyici: scoreboarded pixel, result and filter
// streams plus directed status checks on a reduced 8x4 frame.
module tb_evrisim_denetleyici;

    localparam int G   = 8;
    localparam int Y   = 4;
    localparam int NF  = 4;
    localparam int ZA  = 16;
    localparam int TOP = G * Y;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        ayar_yaz_i = 1'b0;
    logic [1:0]  ayar_adres_i = '0;
    logic [71:0] ayar_filtre_i = '0;
    logic        ayar_gaus_i = 1'b0;
    logic        baslat_i = 1'b0;
    logic [1:0]  filtre_sec_i = '0;
    logic        pik_gecerli_i = 1'b0;
    logic [7:0]  pik_i = '0;
    logic        pik_hazir_o;
    logic        evr_filtre_etkin_o;
    logic [71:0] evr_filtre_o;
    logic        evr_gaus_o;
    logic        evr_veri_etkin_o;
    logic [7:0]  evr_veri_o;
    logic        evr_veri_etkin_i = 1'b0;
    logic [7:0]  evr_veri_i = '0;
    logic        cikis_gecerli_o;
    logic [7:0]  cikis_o;
    logic        mesgul_o;
    logic        bitti_o;
    logic        hata_o;
`ifdef EVRISIM_PERF_SAYAC_EN
    logic [31:0] perf_dongu_o;
    logic [31:0] perf_durak_o;
`endif

    evrisim_denetleyici #(
        .GENISLIK(G), .YUKSEKLIK(Y), .NUM_FILTRE(NF), .ZAMAN_ASIMI(ZA)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .ayar_yaz_i(ayar_yaz_i), .ayar_adres_i(ayar_adres_i),
        .ayar_filtre_i(ayar_filtre_i), .ayar_gaus_i(ayar_gaus_i),
        .baslat_i(baslat_i), .filtre_sec_i(filtre_sec_i),
        .pik_gecerli_i(pik_gecerli_i), .pik_i(pik_i), .pik_hazir_o(pik_hazir_o),
        .evr_filtre_etkin_o(evr_filtre_etkin_o), .evr_filtre_o(evr_filtre_o),
        .evr_gaus_o(evr_gaus_o),
        .evr_veri_etkin_o(evr_veri_etkin_o), .evr_veri_o(evr_veri_o),
        .evr_veri_etkin_i(evr_veri_etkin_i), .evr_veri_i(evr_veri_i),
        .cikis_gecerli_o(cikis_gecerli_o), .cikis_o(cikis_o),
        .mesgul_o(mesgul_o), .bitti_o(bitti_o), .hata_o(hata_o)
`ifdef EVRISIM_PERF_SAYAC_EN
        , .perf_dongu_o(perf_dongu_o), .perf_durak_o(perf_durak_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] v;
        int         t;
    } oge_t;

    oge_t        q_veri[$];
    oge_t        q_cik[$];
    logic [72:0] q_filt[$];

    int n_cmp = 0;
    int n_err = 0;
    int bitti_say = 0;
    int veri_say = 0;

    task automatic chk(input string ad, input logic [71:0] gercek,
                       input logic [71:0] beklenen);
        n_cmp++;
        if (gercek !== beklenen) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", ad, gercek, beklenen);
        end
    endtask

    task automatic beklenmedik(input string ad);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=unexpected output required=none", ad);
    endtask

    oge_t        m_v;
    oge_t        m_c;
    logic [72:0] m_f;

    always @(negedge clk) begin
        if (evr_veri_etkin_o) begin
            veri_say++;
            if (q_veri.size() == 0) beklenmedik("veri_fazla");
            else begin
                m_v = q_veri.pop_front();
                chk("veri_deger", evr_veri_o, m_v.v);
                chk("veri_zaman", cyc, m_v.t);
            end
        end
        if (cikis_gecerli_o) begin
            if (q_cik.size() == 0) beklenmedik("cikis_fazla");
            else begin
                m_c = q_cik.pop_front();
                chk("cikis_deger", cikis_o, m_c.v);
                chk("cikis_zaman", cyc, m_c.t);
            end
        end
        if (evr_filtre_etkin_o) begin
            if (q_filt.size() == 0) beklenmedik("filtre_fazla");
            else begin
                m_f = q_filt.pop_front();
                chk("filtre", evr_filtre_o, m_f[72:1]);
                chk("gaus", evr_gaus_o, m_f[0]);
            end
        end
        if (bitti_o) bitti_say++;
    end

    task automatic ayar(input logic [1:0] a, input logic [71:0] f, input logic g);
        @(posedge clk); #1;
        ayar_yaz_i = 1'b1; ayar_adres_i = a; ayar_filtre_i = f; ayar_gaus_i = g;
        @(posedge clk); #1;
        ayar_yaz_i = 1'b0;
    endtask

    task automatic baslat(input logic [1:0] sec, input logic [71:0] f, input logic g);
        @(posedge clk); #1;
        baslat_i = 1'b1; filtre_sec_i = sec;
        q_filt.push_back({f, g});
        @(posedge clk); #1;
        baslat_i = 1'b0;
        @(negedge clk);
        chk("yukle_mesgul", mesgul_o, 1);
        chk("yukle_hata", hata_o, 0);
        @(negedge clk);
        chk("yukle_tek", evr_filtre_etkin_o, 0);
        chk("hazir_acik", pik_hazir_o, 1);
    endtask

    // desen 0: always valid; desen 1: valid pattern 1,0,0.
    // son_sonuc: issue one result in the same cycle as the final pixel.
    task automatic pikseller(input int desen, input int sinir, input bit son_sonuc);
        int idx = 0;
        int k = 0;
        while (idx < sinir && k < 2000) begin
            @(posedge clk); #1;
            pik_gecerli_i = (desen == 0) || (k % 3 == 0);
            pik_i = 8'(idx);
            k++;
            if (son_sonuc && pik_gecerli_i && idx == TOP - 1) begin
                evr_veri_etkin_i = 1'b1;
                evr_veri_i = 8'hC3;
                q_cik.push_back('{8'hC3, cyc + 1});
            end
            @(negedge clk);
            if (pik_gecerli_i && pik_hazir_o) begin
                q_veri.push_back('{pik_i, cyc + 1});
                idx++;
            end
        end
        if (idx < sinir) chk("piksel_suresi", 32'(idx), 32'(sinir));
        @(posedge clk); #1;
        pik_gecerli_i = 1'b0;
        if (son_sonuc) evr_veri_etkin_i = 1'b0;
    endtask

    task automatic sonuclar(input int n, input int bosluk, input logic [7:0] taban);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            evr_veri_etkin_i = 1'b1;
            evr_veri_i = 8'(taban + 8'(i * 7));
            q_cik.push_back('{evr_veri_i, cyc + 1});
            for (int j = 0; j < bosluk; j++) begin
                @(posedge clk); #1;
                evr_veri_etkin_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        evr_veri_etkin_i = 1'b0;
    endtask

    task automatic sifir_kontrol(input string ad);
        chk({ad, "_hazir"}, pik_hazir_o, 0);
        chk({ad, "_fetkin"}, evr_filtre_etkin_o, 0);
        chk({ad, "_filtre"}, evr_filtre_o, 0);
        chk({ad, "_gaus"}, evr_gaus_o, 0);
        chk({ad, "_vetkin"}, evr_veri_etkin_o, 0);
        chk({ad, "_veri"}, evr_veri_o, 0);
        chk({ad, "_cgec"}, cikis_gecerli_o, 0);
        chk({ad, "_cikis"}, cikis_o, 0);
        chk({ad, "_mesgul"}, mesgul_o, 0);
        chk({ad, "_bitti"}, bitti_o, 0);
        chk({ad, "_hata"}, hata_o, 0);
    endtask

    localparam logic [71:0] BIRLER = 72'h010101010101010101;
    localparam logic [71:0] F1     = 72'h807F01FF0010203040;
    localparam logic [71:0] F2YENI = 72'h0102030405060708F9;
    localparam logic [71:0] F0     = 72'hFEDCBA9876543210AB;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        sifir_kontrol("reset");
        #1 rstn_i = 1'b1;

        ayar(2'd2, BIRLER, 1'b1);
        ayar(2'd1, F1, 1'b0);

        // Frame 1: continuous pixels, then results after input ends.
        veri_say = 0;
        baslat(2'd2, BIRLER, 1'b1);
        pikseller(0, TOP, 0);
        @(negedge clk);
        chk("f1_hazir_kapali", pik_hazir_o, 0);
        @(posedge clk); #1;
        baslat_i = 1'b1; filtre_sec_i = 2'd1;
        @(posedge clk); #1;
        baslat_i = 1'b0;
        ayar(2'd2, F2YENI, 1'b0);
        @(negedge clk);
        chk("f1_mesgul_bosalt", mesgul_o, 1);
        sonuclar(TOP, 0, 8'h5A);
        @(negedge clk);
        chk("f1_bitti", bitti_o, 1);
        chk("f1_bitti_mesgul", mesgul_o, 1);
        @(negedge clk);
        chk("f1_bitti_son", bitti_o, 0);
        chk("f1_mesgul_son", mesgul_o, 0);
        chk("f1_hata", hata_o, 0);
        chk("f1_bitti_say", bitti_say, 1);
        chk("f1_veri_say", veri_say, TOP);
        chk("f1_filtre_tutulu", evr_filtre_o, BIRLER);
        chk("f1_gaus_tutulu", evr_gaus_o, 1);

        // Frame 2: 1,0,0 source, results during input, last one coincident.
        veri_say = 0;
        baslat(2'd1, F1, 1'b0);
        fork
            pikseller(1, TOP, 1);
            sonuclar(TOP - 1, 1, 8'h11);
        join
        @(negedge clk);
        chk("f2_bitti_erken", bitti_o, 0);
        chk("f2_mesgul", mesgul_o, 1);
        @(negedge clk);
        chk("f2_bitti", bitti_o, 1);
        @(negedge clk);
        chk("f2_mesgul_son", mesgul_o, 0);
        chk("f2_hata", hata_o, 0);
        chk("f2_veri_say", veri_say, TOP);
        sonuclar(2, 0, 8'h90);
        repeat (3) @(negedge clk);
        chk("f2_bitti_say", bitti_say, 2);

        // Frame 3: results stop after 10 -> timeout.
        baslat(2'd2, F2YENI, 1'b0);
        pikseller(0, TOP, 0);
        sonuclar(10, 0, 8'h33);
        repeat (16) @(negedge clk);
        chk("f3_hata_erken", hata_o, 0);
        chk("f3_mesgul", mesgul_o, 1);
        @(negedge clk);
        chk("f3_hata", hata_o, 1);
        chk("f3_mesgul_son", mesgul_o, 0);
        repeat (3) @(negedge clk);
        chk("f3_bitti_yok", bitti_say, 2);
        chk("f3_hata_yapiskan", hata_o, 1);

        // Frame 4: start clears hata; reset mid-frame.
        ayar(2'd0, F0, 1'b1);
        baslat(2'd0, F0, 1'b1);
        pikseller(0, 20, 0);
        rstn_i = 1'b0;
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(negedge clk);
        sifir_kontrol("ortareset");
        repeat (3) @(negedge clk);
        chk("f4_bitti_yok", bitti_say, 2);

        // Frame 5: preset bank must read back as zero after reset.
        baslat(2'd0, 72'h0, 1'b0);
        chk("f5_filtre_sifir", evr_filtre_o, 0);
        repeat (2) @(negedge clk);

        chk("q_veri_bos", q_veri.size(), 0);
        chk("q_cik_bos", q_cik.size(), 0);
        chk("q_filt_bos", q_filt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/evrisim_denetleyici.md
Name: evrisim_denetleyici

Overview:
- Sequencer in front of the 3x3 convolution unit.
- Holds a small bank of filter presets written by the host.
- On start: loads the selected preset into the convolution unit, streams exactly GENISLIK*YUKSEKLIK pixels from a valid/ready source, then collects results until the expected output count is reached, or times out.
- Sits between the pixel DMA/source and the convolution unit; reports busy/done/error to the control plane.

Parameters:
GENISLIK, 320, pixels per row
YUKSEKLIK, 240, rows per frame
NUM_FILTRE, 4, number of filter preset slots (power of 2)
ZAMAN_ASIMI, 4096, max idle cycles between result pixels in BOSALT before error

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, synchronous, active-low
ayar_yaz_i  in  1  preset write strobe
ayar_adres_i  in  log2(NUM_FILTRE)  preset slot
ayar_filtre_i  in  72  nine signed 8-bit coeffs, coeff0 in [71:64]
ayar_gaus_i  in  1  preset gaussian (>>4) flag
baslat_i  in  1  start pulse
filtre_sec_i  in  log2(NUM_FILTRE)  preset used by this frame
pik_gecerli_i  in  1  source pixel valid
pik_i  in  8  source pixel
pik_hazir_o  out  1  source ready
evr_filtre_etkin_o  out  1  filter load strobe to conv unit
evr_filtre_o  out  72  filter to conv unit
evr_gaus_o  out  1  gaussian flag to conv unit
evr_veri_etkin_o  out  1  pixel valid to conv unit
evr_veri_o  out  8  pixel to conv unit
evr_veri_etkin_i  in  1  result valid from conv unit
evr_veri_i  in  8  result from conv unit
cikis_gecerli_o  out  1  result valid to sink (no backpressure)
cikis_o  out  8  result to sink
mesgul_o  out  1  high in any state except BOSTA
bitti_o  out  1  one-cycle pulse on frame completion
hata_o  out  1  sticky timeout flag, cleared by next accepted baslat_i

Behaviour:
- Reset (rstn_i low at posedge):
  - All outputs 0; FSM to BOSTA; counters 0.
  - Preset bank cleared to all-zero coeffs, gaus=0.
  - Reset mid-frame aborts immediately; no bitti_o is issued.
- Preset writes:
  - ayar_yaz_i writes slot ayar_adres_i at the clock edge; allowed in any state.
  - A write to the slot the running frame uses does not affect it, because the filter is latched in YUKLE.
- FSM states:
  - BOSTA: pik_hazir_o=0. baslat_i -> YUKLE; latch filtre_sec_i; clear hata_o. baslat_i is ignored in every other state.
  - YUKLE: one cycle. evr_filtre_etkin_o=1 with evr_filtre_o/evr_gaus_o from the latched slot -> AKIS. evr_filtre_o/evr_gaus_o hold their value afterwards.
  - AKIS:
    - pik_hazir_o=1 while giris_sayac < GENISLIK*YUKSEKLIK.
    - On each handshake (pik_gecerli_i & pik_hazir_o), next cycle: evr_veri_etkin_o=1, evr_veri_o=pik_i (1-cycle registered latency). Otherwise evr_veri_etkin_o=0.
    - The handshake that makes giris_sayac reach GENISLIK*YUKSEKLIK moves to BOSALT. pik_hazir_o is 0 from the following cycle.
  - BOSALT:
    - Waits for cikis_sayac == GENISLIK*YUKSEKLIK -> BITTI.
    - Idle counter increments each cycle without evr_veri_etkin_i and resets on each result.
    - Idle counter reaching ZAMAN_ASIMI -> set hata_o, go to BOSTA, no bitti_o.
  - BITTI: one cycle, bitti_o=1 -> BOSTA.
- Result path:
  - cikis_gecerli_o/cikis_o = registered evr_veri_etkin_i/evr_veri_i, 1-cycle latency, in every state.
  - cikis_sayac counts evr_veri_etkin_i only in AKIS/BOSALT.
  - Results beyond GENISLIK*YUKSEKLIK are still forwarded but not counted.
- Counters: giris_sayac and cikis_sayac are 17 bits wide (sized for 320*240=76800). Both are cleared in YUKLE.
- Simultaneous events:
  - Final input handshake and a result in the same cycle: both counted.
  - cikis_sayac reaching the target in the same cycle the idle counter hits ZAMAN_ASIMI: completion wins.

Optional Feature:
- Macro EVRISIM_PERF_SAYAC_EN.
- When defined: extra outputs perf_dongu_o[31:0] (cycles spent in AKIS+BOSALT for the last frame) and perf_durak_o[31:0] (AKIS cycles with pik_hazir_o=1 and pik_gecerli_i=0).
  - Both cleared in YUKLE, frozen after BITTI or timeout, 0 on reset.
  - Both saturate at 32'hFFFFFFFF.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Write slot 2 = {8'd1,...,8'd1}, gaus=1; baslat_i with filtre_sec_i=2 -> exactly one evr_filtre_etkin_o cycle with evr_filtre_o=72'h010101010101010101 and evr_gaus_o=1, then pik_hazir_o=1.
- Continuous source of 76800 pixels, value = index[7:0] -> evr_veri_etkin_o high for 76800 cycles; evr_veri_o matches one cycle later; pik_hazir_o drops after the 76800th handshake.
- Source with pik_gecerli_i toggling 1,0,0 repeatedly -> exactly 76800 evr_veri_etkin_o pulses, no duplicates or drops.
- Model returns 76800 results after the input ends -> bitti_o pulses once, one cycle after the last result is counted; mesgul_o falls the same cycle bitti_o ends; hata_o=0.
- Model stops after 100 results, ZAMAN_ASIMI=16 -> hata_o=1 exactly 16 idle cycles after the last result; no bitti_o; the next baslat_i clears hata_o.
- rstn_i low for 1 cycle at input pixel 5000 -> all outputs 0 the next cycle, state BOSTA, preset bank zeroed; a baslat_i while mesgul_o=1 is ignored.
